// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared widths, defaults and FSM encoding for the instruction cache
package inst_cache_pkg;
    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int INDEX_BITS_DEF = 4;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;
endpackage

// File: rtl/inst_cache_ram.sv
// rtl/inst_cache_ram.sv - direct-mapped line store: async read, sync write, one-cycle valid clear
module inst_cache_ram
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_W      = ADDR_W - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [WORD_W-1:0]     rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [WORD_W-1:0]     wr_data_i,
    input  logic                  wr_valid_i,
    input  logic                  clear_i
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

    // A clear in the same cycle as a write wins, so a flushed refill lands invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= wr_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped one-word-line instruction cache with blocking refill
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [31:0]       cpu_addr_i,
    output logic [31:0]       cpu_data_o,
    output logic              stall_req_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [31:0]       mem_addr_o,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q;
    logic [31:2]       addr_q;
    logic              flushed_q;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_q;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0] rd_data;
    logic              hit;
    logic              idle_hit;
    logic              idle_miss;
    logic              refill_done;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    inst_cache_ram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (cpu_addr_i[INDEX_BITS+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (refill_done),
        .wr_index_i (addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (addr_q[31:INDEX_BITS+2]),
        .wr_data_i  (mem_data_i),
        .wr_valid_i (!flushed_q),
        .clear_i    (flush_i)
    );

    assign hit         = rd_valid && (rd_tag == cpu_addr_i[31:INDEX_BITS+2]);
    assign idle_hit    = (state_q == ST_IDLE) && cpu_ce_i && hit;
    assign idle_miss   = (state_q == ST_IDLE) && cpu_ce_i && !hit;
    assign refill_done = (state_q == ST_REFILL) && mem_ack_i;

    // flushed_q remembers a flush seen mid-refill so the returning line is written invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            flushed_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (idle_hit) begin
                        hit_cnt_q <= hit_cnt_q + CNT_ONE;
                    end
                    if (idle_miss) begin
                        miss_cnt_q <= miss_cnt_q + CNT_ONE;
                        addr_q     <= cpu_addr_i[31:2];
                        flushed_q  <= 1'b0;
                        state_q    <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (flush_i) begin
                        flushed_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_data_o  = '0;
        stall_req_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        if (state_q == ST_IDLE) begin
            if (idle_hit) begin
                cpu_data_o = rd_data;
            end
            stall_req_o = idle_miss;
        end else begin
            mem_req_o  = 1'b1;
            mem_addr_o = {addr_q, 2'b00};
            if (mem_ack_i) begin
                cpu_data_o = cpu_ce_i ? mem_data_i : '0;
            end else begin
                stall_req_o = 1'b1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - randomized and directed checks of inst_cache against a line-level model
module tb_inst_cache;
    localparam int IB = 4;
    localparam int CW = 2;
    localparam int NL = 1 << IB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_ce_i = 1'b0;
    logic [31:0]   cpu_addr_i = '0;
    logic [31:0]   cpu_data_o;
    logic          stall_req_o;
    logic          flush_i = 1'b0;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_data_i = '0;
    logic          mem_ack_i = 1'b0;
    logic [CW-1:0] hit_cnt_o;
    logic [CW-1:0] miss_cnt_o;

    always #5 clk = ~clk;

    inst_cache #(.INDEX_BITS(IB), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce_i    (cpu_ce_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_o  (cpu_data_o),
        .stall_req_o (stall_req_o),
        .flush_i     (flush_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0) return 32'h34011100;
        return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Backing memory: answers after fixed_lat REFILL cycles (random 1..4 when 0), stray acks in idle.
    int fixed_lat = 0;
    int rcnt = 0;
    int target = 1;
    bit force_ack = 1'b0;

    always @(posedge clk) begin
        #2;
        if (mem_req_o) begin
            if (rcnt == 0) target = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            rcnt++;
            if (rcnt >= target) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mem_word(mem_addr_o);
                rcnt       = 0;
            end else begin
                mem_ack_i  = 1'b0;
                mem_data_i = $urandom;
            end
        end else begin
            rcnt       = 0;
            mem_ack_i  = force_ack || ($urandom_range(0, 9) == 0);
            mem_data_i = $urandom;
        end
    end

    // Reference model: cache as an array of remembered word addresses plus a pending-refill record.
    bit            m_on = 1'b0;
    bit            m_busy;
    logic [31:0]   m_la;
    bit            m_fl;
    bit            m_valid [NL];
    logic [31:0]   m_addr  [NL];
    logic [31:0]   m_data  [NL];
    logic [CW-1:0] m_hc;
    logic [CW-1:0] m_mc;

    task automatic m_reset();
        m_busy = 1'b0;
        m_la   = '0;
        m_fl   = 1'b0;
        m_hc   = '0;
        m_mc   = '0;
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (m_on) begin
            int          idx;
            int          li;
            bit          hit;
            bit          wv;
            logic [31:0] e_data;
            bit          e_stall;
            bit          e_req;
            logic [31:0] e_addr;
            idx = int'(cpu_addr_i[IB+1:2]);
            hit = m_valid[idx] && (m_addr[idx][31:IB+2] == cpu_addr_i[31:IB+2]);
            e_data = '0; e_stall = 1'b0; e_req = 1'b0; e_addr = '0;
            if (!m_busy) begin
                if (cpu_ce_i && hit) e_data = m_data[idx];
                e_stall = cpu_ce_i && !hit;
            end else begin
                e_req  = 1'b1;
                e_addr = {m_la[31:2], 2'b00};
                if (mem_ack_i) e_data = cpu_ce_i ? mem_data_i : 32'h0;
                else e_stall = 1'b1;
            end
            chk("cpu_data", cpu_data_o, e_data);
            chk("stall", {31'b0, stall_req_o}, {31'b0, e_stall});
            chk("mem_req", {31'b0, mem_req_o}, {31'b0, e_req});
            chk("mem_addr", mem_addr_o, e_addr);
            chk("hit_cnt", 32'(hit_cnt_o), 32'(m_hc));
            chk("miss_cnt", 32'(miss_cnt_o), 32'(m_mc));
            if (!rst) begin
                m_reset();
            end else if (!m_busy) begin
                if (cpu_ce_i && hit) m_hc = m_hc + 1'b1;
                else if (cpu_ce_i) begin
                    m_mc = m_mc + 1'b1;
                    m_la = cpu_addr_i;
                    m_fl = 1'b0;
                    m_busy = 1'b1;
                end
                if (flush_i) for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
            end else begin
                wv = !(m_fl || flush_i);
                if (flush_i) begin
                    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
                    m_fl = 1'b1;
                end
                if (mem_ack_i) begin
                    li = int'(m_la[IB+1:2]);
                    m_valid[li] = wv;
                    m_addr[li]  = m_la;
                    m_data[li]  = mem_data_i;
                    m_busy      = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_unstall(input string name);
        int n = 0;
        while (stall_req_o === 1'b1 && n < 30) begin
            step();
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk({name, "_timeout"}, n, 0);
    endtask

    task automatic do_fetch(input logic [31:0] a, output bit miss, output logic [31:0] d);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = a;
        @(negedge clk);
        miss = stall_req_o;
        wait_unstall("fetch");
        d = cpu_data_o;
        step();
        cpu_ce_i = 1'b0;
    endtask

    initial begin
        bit          miss;
        logic [31:0] d;
        int          seq [5] = '{1, 2, 3, 0, 1};

        rst = 1'b0;
        step();
        m_reset();
        m_on = 1'b1;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_stall", {31'b0, stall_req_o}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_miss_cnt", 32'(miss_cnt_o), 32'h0);

        // Cold miss with ack on the third REFILL cycle, then a zero-latency hit.
        step();
        fixed_lat  = 3;
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h0;
        @(negedge clk);
        chk("cold_stall_miss", {31'b0, stall_req_o}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            chk("cold_stall_refill", {31'b0, stall_req_o}, 32'h1);
            chk("cold_mem_req", {31'b0, mem_req_o}, 32'h1);
        end
        step();
        @(negedge clk);
        chk("cold_ack_stall", {31'b0, stall_req_o}, 32'h0);
        chk("cold_ack_data", cpu_data_o, 32'h34011100);
        step();
        @(negedge clk);
        chk("hit_data", cpu_data_o, 32'h34011100);
        chk("hit_stall", {31'b0, stall_req_o}, 32'h0);
        chk("hit_mem_req", {31'b0, mem_req_o}, 32'h0);
        chk("cold_miss_cnt", 32'(miss_cnt_o), 32'h1);
        step();
        cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("hit_cnt_one", 32'(hit_cnt_o), 32'h1);
        step();
        fixed_lat = 0;

        // Conflict on index 1.
        do_fetch(32'h4, miss, d);
        chk("conf_fill_miss", {31'b0, miss}, 32'h1);
        do_fetch(32'h44, miss, d);
        chk("conf_evict_miss", {31'b0, miss}, 32'h1);
        chk("conf_evict_data", d, mem_word(32'h44));
        do_fetch(32'h4, miss, d);
        chk("conf_refetch_miss", {31'b0, miss}, 32'h1);
        do_fetch(32'h4, miss, d);
        chk("conf_rehit", {31'b0, miss}, 32'h0);

        // Flush in idle: same-cycle lookup sees old contents, next fetch misses.
        do_fetch(32'h8, miss, d);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h8;
        flush_i    = 1'b1;
        @(negedge clk);
        chk("flush_same_cycle_hit", {31'b0, stall_req_o}, 32'h0);
        chk("flush_same_cycle_data", cpu_data_o, mem_word(32'h8));
        step();
        flush_i  = 1'b0;
        cpu_ce_i = 1'b0;
        do_fetch(32'h8, miss, d);
        chk("flush_idle_miss", {31'b0, miss}, 32'h1);

        // Flush during refill: data still returned, line not kept.
        fixed_lat  = 4;
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h10C;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        wait_unstall("flush_refill");
        chk("flush_refill_data", cpu_data_o, mem_word(32'h10C));
        step();
        cpu_ce_i  = 1'b0;
        fixed_lat = 0;
        do_fetch(32'h10C, miss, d);
        chk("flush_refill_miss", {31'b0, miss}, 32'h1);

        // Reset two cycles into REFILL, then a stray ack.
        fixed_lat  = 6;
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h20;
        step();
        step();
        rst      = 1'b0;
        cpu_ce_i = 1'b0;
        step();
        rst       = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        chk("rrst_mem_req", {31'b0, mem_req_o}, 32'h0);
        chk("rrst_stall", {31'b0, stall_req_o}, 32'h0);
        chk("rrst_hit_cnt", 32'(hit_cnt_o), 32'h0);
        chk("rrst_miss_cnt", 32'(miss_cnt_o), 32'h0);
        step();
        force_ack = 1'b0;
        @(negedge clk);
        chk("rrst_stray_req", {31'b0, mem_req_o}, 32'h0);
        chk("rrst_stray_miss_cnt", 32'(miss_cnt_o), 32'h0);
        step();
        fixed_lat = 0;
        do_fetch(32'h20, miss, d);
        chk("rrst_refetch_miss", {31'b0, miss}, 32'h1);

        // Counter wrap with a 2-bit hit counter.
        do_fetch(32'h30, miss, d);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h30;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("wrap_hit_cnt", 32'(hit_cnt_o), 32'(seq[i]));
        end
        step();
        cpu_ce_i = 1'b0;

        // Random traffic: small tag set to force conflicts, occasional flush and reset.
        for (int c = 0; c < 2000; c++) begin
            step();
            rst        = ($urandom_range(0, 299) != 0);
            cpu_ce_i   = ($urandom_range(0, 3) != 0);
            cpu_addr_i = {$urandom_range(0, 1) == 1, 23'h0, 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            flush_i    = ($urandom_range(0, 24) == 0);
        end
        step();
        rst      = 1'b1;
        cpu_ce_i = 1'b0;
        flush_i  = 1'b0;
        repeat (8) step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
